// File: rtl/store_merge_pkg.sv
// -----------------------------------------------------------------------------
// store_merge_pkg
// Shared definitions for the store path and the load-side extension logic:
//   - store size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word)
//   - FSM state type for the read-modify-write sequencer
//   - helper functions for alignment and read requirements
// -----------------------------------------------------------------------------
package store_merge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WRITE
  } state_t;

  // Half needs an even address, word (and the 2'b11 alias) a word-aligned one.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Sub-word stores must read the old word first to preserve the other lanes.
  function automatic logic needs_read(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// -----------------------------------------------------------------------------
// store_lane_merge
// Combinational little-endian lane merge. Replaces the addressed byte or half
// of old_word with the low byte/half of data; a word store replaces all lanes.
// Ports:
//   old_word    in  32  word captured from memory
//   data        in  32  right-justified store data
//   size        in  2   store size encoding
//   addr_lo     in  2   byte address bits [1:0]
//   merged_word out 32  word to be written back
// -----------------------------------------------------------------------------
module store_lane_merge
  import store_merge_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged_word
);

  // Half stores use only addr_lo[1]; addr_lo[0] is ignored for lane choice.
  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_BYTE: merged_word[{addr_lo, 3'b000} +: 8]        = data[7:0];
      SZ_HALF: merged_word[{addr_lo[1], 4'b0000} +: 16]   = data[15:0];
      default: merged_word                                = data;
    endcase
  end

endmodule

// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
// Store unit performing read-modify-write for byte/half stores and a direct
// write for word stores against a word-addressed synchronous memory.
//   word:       IDLE -> WRITE                      (done 1 cycle after accept)
//   byte/half:  IDLE -> READ -> CAPTURE -> WRITE   (done 3 cycles after accept)
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_addr/req_data/req_size    store byte address, data, size
//   mem_addr/mem_re/mem_rdata     memory word address, read strobe, read data
//   mem_we/mem_wdata              memory write strobe and merged write word
//   done                          one-cycle completion pulse
//   misalign                      pulses with done for a rejected store
// Configuration:
//   STORE_MERGE_ALIGN_CHECK_EN    when defined, misaligned half/word stores
//                                 skip memory access and report misalign;
//                                 otherwise misalign is tied low.
// -----------------------------------------------------------------------------
module store_merge
  import store_merge_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              misalign
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q;
  logic [1:0]        lane_q;
  logic [31:0]       data_q;
  logic [1:0]        size_q;
  logic [31:0]       old_q;
  logic              misalign_q;
  logic              accept;
  logic              bad_align;

  assign accept = req_valid && (state_q == ST_IDLE);

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  assign bad_align = is_misaligned(req_size, req_addr[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request fields are captured only on acceptance so the memory address and
  // merge inputs stay stable for the whole operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_addr_q <= '0;
      lane_q      <= '0;
      data_q      <= '0;
      size_q      <= '0;
      misalign_q  <= 1'b0;
    end else if (accept) begin
      word_addr_q <= req_addr[ADDR_W+1:2];
      lane_q      <= req_addr[1:0];
      data_q      <= req_data;
      size_q      <= req_size;
      misalign_q  <= bad_align;
    end
  end

  // Read data arrives the cycle after mem_re, i.e. while in CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        old_q <= '0;
    else if (state_q == ST_CAPTURE) old_q <= mem_rdata;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad_align || !needs_read(req_size)) state_d = ST_WRITE;
          else                                    state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_re  = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we  = !misalign_q;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef STORE_MERGE_ALIGN_CHECK_EN
  assign misalign = (state_q == ST_WRITE) && misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign mem_addr = word_addr_q;

  store_lane_merge u_lane_merge (
    .old_word    (old_q),
    .data        (data_q),
    .size        (size_q),
    .addr_lo     (lane_q),
    .merged_word (mem_wdata)
  );

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of the data memory.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  store request present.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid and req_ready.
REQ-006 SHALL have port req_addr  input  32  byte address of store.
REQ-007 SHALL have port req_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port mem_addr  output  ADDR_W  word address, equals req_addr[ADDR_W+1:2] of the latched request.
REQ-010 SHALL have port mem_re  output  1  memory read strobe.
REQ-011 SHALL have port mem_rdata  input  32  read data, valid exactly one cycle after mem_re.
REQ-012 SHALL have port mem_we  output  1  memory write strobe.
REQ-013 SHALL have port mem_wdata  output  32  merged write word.
REQ-014 SHALL have port done  output  1  one-cycle pulse at completion.
REQ-015 SHALL have port misalign  output  1  one-cycle pulse with done for a rejected misaligned store.

Function
REQ-016 SHALL latch addr, data, size on acceptance; inputs are ignored while busy.
REQ-017 SHALL implement FSM states IDLE, READ, CAPTURE, WRITE.
REQ-018 Word store SHALL go IDLE->WRITE; mem_we, mem_wdata=req_data and done asserted in the cycle after acceptance (latency 1).
REQ-019 Byte/half store SHALL go IDLE->READ (mem_re=1) ->CAPTURE (latch mem_rdata) ->WRITE (mem_we=1, done=1) ->IDLE; latency 3.
REQ-020 Byte lanes SHALL be little-endian: byte lane n=addr[1:0] occupies bits [8n+7:8n]; half at addr[1] occupies [16*addr[1]+15:16*addr[1]].
REQ-021 Merge SHALL replace only the addressed lane(s) with the low byte/half of req_data; all other bits SHALL equal captured mem_rdata exactly.
REQ-022 mem_re and mem_we SHALL never be high in the same cycle; each is high for exactly one cycle per store.
REQ-023 A new request SHALL be acceptable in the cycle after WRITE (req_ready back-to-back with done deasserting).
REQ-024 mem_addr SHALL hold stable from READ through WRITE.

Reset
REQ-025 rst SHALL force IDLE immediately; reset values: req_ready=1 after release, mem_re=0, mem_we=0, done=0, misalign=0, mem_addr=0, mem_wdata=0.
REQ-026 rst asserted mid-operation SHALL abort the store with no write issued and no done pulse.

Configuration
REQ-027 Macro STORE_MERGE_ALIGN_CHECK_EN SHALL compile in alignment checking.
REQ-028 With it: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip all memory access, pulse done and misalign together one cycle after acceptance.
REQ-029 Without it: misalign SHALL be tied 0; half ignores addr[0], word ignores addr[1:0].

Structure
REQ-030 Shared package SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef, also used by the load-side extension logic.
REQ-031 Lane merge SHALL be a combinational sub-module store_lane_merge (inputs old word, data, size, addr[1:0]; output merged word); FSM stays in store_merge.

Verification
REQ-032 Word store addr 0x10, data 0xDEADBEEF -> cycle+1 mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, done=1, mem_re never high.
REQ-033 Byte store addr 0x13, data 0x000000AB, memory holds 0x11223344 -> mem_re cycle+1, mem_we cycle+3 with mem_wdata=0xAB223344.
REQ-034 Half store addr 0x06, data 0x0000CAFE, memory holds 0x11223344 -> mem_wdata=0xCAFE3344; half at addr 0x04 -> 0x1122CAFE.
REQ-035 With macro: half store addr 0x05 -> done=misalign=1 at cycle+1, no mem_re/mem_we; without macro same request writes lane 0-1.
REQ-036 rst asserted during CAPTURE -> no mem_we, no done, req_ready=1 after release; back-to-back byte stores each show exactly one mem_re and one mem_we.
